rr_grant_arbiter: RTL

- Shares one downstream resource among DATA_WIDTH requesters.
- Grants ownership to one requester at a time. The owner keeps the grant until it asserts release or a hold timeout fires.
- Selection is round-robin by default, with a fixed highest-index-first mode. Grant index width matches the codebase priority-encoder index convention.
- Sits between requester agents and the shared datapath; gnt_idx drives the datapath mux select.

---
 rtl/rr_grant_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/rr_grant_arbiter.sv
// Ownership arbiter: grants one of DATA_WIDTH requesters until release or hold timeout.
// Round-robin selection by default, highest-index-first when fixed_prio is set.
module rr_grant_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int INDEX_WIDTH    = $clog2(DATA_WIDTH) + 1,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  req_in,
    input  logic                   fixed_prio,
    input  logic                   release_in,
    output logic                   gnt_valid,
    output logic [INDEX_WIDTH-1:0] gnt_idx,
    output logic [DATA_WIDTH-1:0]  gnt_onehot,
    output logic                   timeout_err
);

    localparam int SEL_W = $clog2(DATA_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t                 state_reg;
    logic [SEL_W-1:0]       rr_ptr_reg;
    logic [CNT_WIDTH-1:0]   hold_cnt_reg;
    logic                   gnt_valid_reg;
    logic [INDEX_WIDTH-1:0] gnt_idx_reg;
    logic [DATA_WIDTH-1:0]  gnt_onehot_reg;
    logic                   timeout_err_reg;

    logic [SEL_W-1:0]       rr_winner;
    logic                   rr_found;
    logic [SEL_W-1:0]       rr_cand;
    logic [SEL_W-1:0]       fx_winner;
    logic [SEL_W-1:0]       winner_next;
    logic [DATA_WIDTH-1:0]  onehot_next;
    logic                   any_req;
    logic                   timeout_hit;
    logic                   arb_cycle;

    // Walk downward from rr_ptr with wraparound; the first set request wins.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        rr_cand   = '0;
        for (int off = 0; off < DATA_WIDTH; off++) begin
            if (off <= int'(rr_ptr_reg))
                rr_cand = SEL_W'(int'(rr_ptr_reg) - off);
            else
                rr_cand = SEL_W'(int'(rr_ptr_reg) + DATA_WIDTH - off);
            if (!rr_found && req_in[rr_cand]) begin
                rr_found  = 1'b1;
                rr_winner = rr_cand;
            end
        end
    end

    always_comb begin
        fx_winner = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (req_in[i])
                fx_winner = SEL_W'(i);
        end
    end

    assign winner_next = fixed_prio ? fx_winner : rr_winner;
    assign any_req     = |req_in;

    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_onehot
            assign onehot_next[gi] = (winner_next == SEL_W'(gi));
        end
    endgenerate

    // An explicit release in the same cycle takes precedence over the timeout.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_reg == OWN) &&
                         (hold_cnt_reg == CNT_WIDTH'(TIMEOUT_CYCLES)) && !release_in;
    assign arb_cycle   = (state_reg == IDLE) || release_in || timeout_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            rr_ptr_reg      <= SEL_W'(DATA_WIDTH - 1);
            hold_cnt_reg    <= '0;
            gnt_valid_reg   <= 1'b0;
            gnt_idx_reg     <= '0;
            gnt_onehot_reg  <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            timeout_err_reg <= timeout_hit;
            if (arb_cycle) begin
                if (any_req) begin
                    state_reg      <= OWN;
                    gnt_valid_reg  <= 1'b1;
                    gnt_idx_reg    <= INDEX_WIDTH'(winner_next);
                    gnt_onehot_reg <= onehot_next;
                    rr_ptr_reg     <= (winner_next == '0) ? SEL_W'(DATA_WIDTH - 1)
                                                          : winner_next - 1'b1;
                    hold_cnt_reg   <= CNT_WIDTH'(1);
                end else begin
                    state_reg      <= IDLE;
                    gnt_valid_reg  <= 1'b0;
                    gnt_idx_reg    <= '0;
                    gnt_onehot_reg <= '0;
                    hold_cnt_reg   <= '0;
                end
            end else if ((state_reg == OWN) && (hold_cnt_reg != '1)) begin
                hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
        end
    end

    assign gnt_valid   = gnt_valid_reg;
    assign gnt_idx     = gnt_idx_reg;
    assign gnt_onehot  = gnt_onehot_reg;
    assign timeout_err = timeout_err_reg;

endmodule
